// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and default widths for the cycle controller
package cpu_ctrl_pkg;
  localparam int COUNT_WIDTH_DEF = 32;
  localparam int DIV_WIDTH_DEF = 4;
  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;
endpackage

// File: rtl/enable_divider.sv
// enable_divider: holds the divider period and ticks once per div_reg+1 RUN cycles
module enable_divider
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] val,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] div_cnt;
  assign tick = run && (div_cnt == div_reg);
  // Counter idles at 0 outside RUN so the first RUN cycle always starts a fresh period
  always_ff @(posedge clock) begin
    if (reset) begin
      div_reg <= '0;
      div_cnt <= '0;
    end else begin
      div_reg <= load ? val : div_reg;
      div_cnt <= (!run || div_cnt == div_reg) ? '0 : div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/cycle_controller.sv
// cycle_controller: HALT/RUN/STEP sequencer producing a divided CPU advance enable
module cycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int DIV_WIDTH   = DIV_WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run_req,
  input  logic                   halt_req,
  input  logic                   step_req,
  input  logic                   div_load,
  input  logic [DIV_WIDTH-1:0]   div_val,
  output logic                   cpu_enable,
  output logic [1:0]             state,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] cycle_count
);
  localparam logic [1:0] S_HALT = HALT;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_STEP = STEP;
  logic [1:0] state_nx;
  logic       tick;
  enable_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .clock (clock),
    .reset (reset),
    .run   (state == S_RUN),
    .load  (div_load && state == S_HALT),
    .val   (div_val),
    .tick  (tick)
  );
  // STEP and the unused encoding both fall back to HALT
  always_comb begin
    state_nx = state == S_HALT ? (halt_req ? S_HALT : step_req ? S_STEP : run_req ? S_RUN : S_HALT)
             : state == S_RUN  ? (halt_req ? S_HALT : S_RUN)
             : S_HALT;
  end
  assign cpu_enable = tick || state == S_STEP;
  assign halted     = state == S_HALT;
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_HALT;
      cycle_count <= '0;
    end else begin
      state       <= state_nx;
      cycle_count <= cpu_enable ? cycle_count + 1'b1 : cycle_count;
    end
  end
endmodule

// File: tb/tb_cycle_controller.sv
// tb_cycle_controller: scoreboard bench, expected enable pulses queued by stimulus and popped by a monitor
module tb_cycle_controller;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run_req = 1'b0;
  logic       halt_req = 1'b0;
  logic       step_req = 1'b0;
  logic       div_load = 1'b0;
  logic [3:0] div_val = 4'd0;
  logic       cpu_enable;
  logic [1:0] state;
  logic       halted;
  logic [3:0] cycle_count;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int model = 0;
  int t;
  typedef struct {int cyc; int cnt;} ev_t;
  ev_t exp_q[$];

  cycle_controller #(.COUNT_WIDTH(4), .DIV_WIDTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .div_load    (div_load),
    .div_val     (div_val),
    .cpu_enable  (cpu_enable),
    .state       (state),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic at(input int c);
    while (cyc < c) nxt();
  endtask

  task automatic pulse(input int c);
    exp_q.push_back('{c, model});
    model = (model + 1) % 16;
  endtask

  task automatic obs(input string n, input int st, input int cnt);
    @(negedge clock);
    check({n, "_state"}, int'(state), st);
    check({n, "_halted"}, int'(halted), int'(st == 0));
    check({n, "_count"}, int'(cycle_count), cnt);
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clock);
      if (cpu_enable) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pulse_unexpected: enable at cycle %0d, none expected", cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_count", int'(cycle_count), e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    nxt();
    nxt();
    obs("reset", 0, 0);
    reset = 1'b0;
    repeat (10) begin
      nxt();
      obs("idle", 0, 0);
    end
    // div_load together with run_req: new period of 3 applies immediately
    nxt();
    t = cyc;
    div_load = 1'b1; div_val = 4'd2; run_req = 1'b1;
    pulse(t + 3); pulse(t + 6); pulse(t + 9);
    nxt();
    div_load = 1'b0; run_req = 1'b0;
    obs("run_entry", 1, 0);
    at(t + 10);
    halt_req = 1'b1;
    obs("div2_count", 1, 3);
    nxt();
    halt_req = 1'b0;
    obs("div2_halt", 0, 3);
    // div_reg=0: enable every RUN cycle, halt does not suppress the enable due now
    nxt();
    div_load = 1'b1; div_val = 4'd0;
    nxt();
    div_load = 1'b0;
    t = cyc;
    run_req = 1'b1;
    for (int i = 1; i <= 5; i++) pulse(t + i);
    nxt();
    run_req = 1'b0;
    at(t + 5);
    halt_req = 1'b1;
    obs("halt_due", 1, 7);
    nxt();
    halt_req = 1'b0;
    obs("halt_after", 0, 8);
    // single step with div_reg=2, requests during STEP ignored
    div_load = 1'b1; div_val = 4'd2;
    nxt();
    div_load = 1'b0;
    t = cyc;
    step_req = 1'b1;
    pulse(t + 1);
    nxt();
    step_req = 1'b0; run_req = 1'b1;
    obs("step_state", 2, 8);
    nxt();
    run_req = 1'b0;
    obs("step_done", 0, 9);
    // div_load in RUN must not change the period
    t = cyc;
    run_req = 1'b1;
    pulse(t + 3); pulse(t + 6);
    nxt();
    run_req = 1'b0;
    at(t + 2);
    div_load = 1'b1; div_val = 4'd0;
    nxt();
    div_load = 1'b0;
    at(t + 7);
    halt_req = 1'b1;
    obs("div_hold", 1, 11);
    nxt();
    halt_req = 1'b0;
    obs("div_hold_halt", 0, 11);
    // 4-bit count wrap over 17 enables
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    model = 0;
    obs("reset2", 0, 0);
    nxt();
    t = cyc;
    run_req = 1'b1;
    for (int i = 1; i <= 17; i++) pulse(t + i);
    nxt();
    run_req = 1'b0;
    at(t + 17);
    halt_req = 1'b1;
    obs("wrap_last", 1, 0);
    nxt();
    halt_req = 1'b0;
    obs("wrap_count", 0, 1);
    // reset during RUN at count 7 overrides a simultaneous request
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    model = 0;
    nxt();
    t = cyc;
    run_req = 1'b1;
    for (int i = 1; i <= 8; i++) pulse(t + i);
    nxt();
    run_req = 1'b0;
    at(t + 8);
    reset = 1'b1; run_req = 1'b1;
    obs("rst_run", 1, 7);
    nxt();
    reset = 1'b0; run_req = 1'b0;
    obs("rst_after", 0, 0);
    check("rst_enable", int'(cpu_enable), 0);
    repeat (3) begin
      nxt();
      obs("post_rst", 0, 0);
    end
    nxt();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
